// File: rtl/byte_mem_initiator_pkg.sv
// Shared types and helpers for the byte-serial memory initiator.
// Byte lane 0 is the most significant byte, so memory order is big-endian.
package byte_mem_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = 3;

    localparam logic [CNT_W-1:0] LAST_WR_CNT = CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] LAST_RD_CNT = CNT_W'(BYTES_PER_WORD);

    function automatic logic [7:0] get_byte(input logic [31:0]      word,
                                            input logic [CNT_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (idx == CNT_W'(i)) begin
                b = word[31-8*i -: 8];
            end
        end
        return b;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0]      word,
                                             input logic [CNT_W-1:0] idx,
                                             input logic [7:0]       b);
        logic [31:0] w;
        w = word;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (idx == CNT_W'(i)) begin
                w[31-8*i -: 8] = b;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/byte_mem_initiator.sv
// Splits one 32-bit load/store into four sequential byte accesses on a
// single-port byte RAM, stalling the pipeline until the word is complete.
//
//   state | meaning
//   IDLE  | waiting for req_rd/req_wr; latches base, data and op on accept
//   WR    | cnt 0..3: one byte write per cycle, MSB first
//   RD    | cnt 0..3 issue reads; cnt 1..4 capture the byte read one cycle earlier
//   DONE  | one-cycle ready pulse, strobes off, back to IDLE
module byte_mem_initiator
    import byte_mem_initiator_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              freeze,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0]  base, base_nxt;
    logic [31:0]        wdata_lat, wdata_nxt;

    logic               ready_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [7:0]         mem_wdata_d;
    logic               mem_we_d;
    logic               mem_re_d;

    logic               req_valid;
    logic               capture;
    logic               unused_addr_bits;

    assign req_valid        = req_rd | req_wr;
    assign freeze           = req_valid & ~ready;
    assign capture          = (state == RD) && (cnt != '0);
    assign unused_addr_bits = ^req_addr[31:ADDR_W];

    // All memory-side outputs are registered, so they are computed from the
    // next-state values and land in the same cycle the FSM enters WR/RD.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            base      <= '0;
            wdata_lat <= '0;
            ready     <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            base      <= base_nxt;
            wdata_lat <= wdata_nxt;
            ready     <= ready_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_we    <= mem_we_d;
            mem_re    <= mem_re_d;
            if (capture) begin
                rdata <= put_byte(rdata, cnt - CNT_W'(1), mem_rdata);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        base_nxt  = base;
        wdata_nxt = wdata_lat;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    base_nxt  = req_addr[ADDR_W-1:0];
                    wdata_nxt = req_wdata;
                    cnt_nxt   = '0;
                    state_nxt = req_wr ? WR : RD;
                end
            end
            WR: begin
                if (cnt == LAST_WR_CNT) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RD: begin
                if (cnt == LAST_RD_CNT) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        mem_we_d    = (state_nxt == WR);
        mem_re_d    = (state_nxt == RD) && (cnt_nxt < LAST_RD_CNT);
        ready_d     = (state_nxt == DONE);
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if (mem_we_d || mem_re_d) begin
            mem_addr_d = base_nxt + ADDR_W'(cnt_nxt);
        end
        if (mem_we_d) begin
            mem_wdata_d = get_byte(wdata_nxt, cnt_nxt);
        end
    end

endmodule

// File: tb/tb_byte_mem_initiator.sv
// Scoreboard bench: stimulus tasks queue expected RAM strobes and ready
// pulses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_byte_mem_initiator;

    localparam int ADDR_W = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req_rd = 1'b0;
    logic              req_wr = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              freeze;
    logic              ready;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata = '0;

    byte_mem_initiator #(.ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .freeze    (freeze),
        .ready     (ready),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    logic [31:0] cyc = '0;
    always @(posedge clock) cyc <= cyc + 32'd1;

    // Byte RAM: write and read both sample on the rising edge.
    logic [7:0] ram [256];
    initial foreach (ram[i]) ram[i] = 8'h00;
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic [31:0] cyc;
        logic [7:0]  addr;
        logic [7:0]  data;
    } byte_ev_t;

    typedef struct {
        logic [31:0] cyc;
        logic [31:0] rdata;
    } rdy_ev_t;

    byte_ev_t wr_q [$];
    byte_ev_t rd_q [$];
    rdy_ev_t  rdy_q [$];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        byte_ev_t be;
        rdy_ev_t  re;
        if (mem_we) begin
            if (wr_q.size() == 0) chk("unexpected_mem_we", 32'd1, 32'd0);
            else begin
                be = wr_q.pop_front();
                chk("wr_cycle", cyc, be.cyc);
                chk("wr_addr", 32'(mem_addr), 32'(be.addr));
                chk("wr_data", 32'(mem_wdata), 32'(be.data));
            end
        end
        if (mem_re) begin
            if (rd_q.size() == 0) chk("unexpected_mem_re", 32'd1, 32'd0);
            else begin
                be = rd_q.pop_front();
                chk("rd_cycle", cyc, be.cyc);
                chk("rd_addr", 32'(mem_addr), 32'(be.addr));
            end
        end
        if (ready) begin
            if (rdy_q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
            else begin
                re = rdy_q.pop_front();
                chk("ready_cycle", cyc, re.cyc);
                chk("rdata", rdata, re.rdata);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        req_rd = 1'b0;
        req_wr = 1'b0;
        repeat (n) step();
    endtask

    // Store issued in the current cycle T; request fields are scrambled after
    // acceptance and optionally dropped at cycle T+drop_at.
    task automatic do_store(input logic [7:0] addr, input logic [31:0] data,
                            input bit both, input int drop_at);
        logic [31:0] t;
        bit          valid;
        byte_ev_t    ev;
        rdy_ev_t     rv;
        t         = cyc;
        valid     = 1'b1;
        req_wr    = 1'b1;
        req_rd    = both;
        req_addr  = {24'hA5C3E1, addr};
        req_wdata = data;
        for (int k = 0; k < 4; k++) begin
            ev.cyc  = t + 32'(1 + k);
            ev.addr = addr + 8'(k);
            ev.data = data[31-8*k -: 8];
            wr_q.push_back(ev);
        end
        rv.cyc   = t + 32'd5;
        rv.rdata = exp_rdata;
        rdy_q.push_back(rv);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("store_freeze", 32'(freeze), 32'(valid && (i <= 4)));
            step();
            if (i == 0) begin
                req_addr  = ~req_addr;
                req_wdata = ~req_wdata;
            end
            if (i + 1 == drop_at) begin
                req_wr = 1'b0;
                req_rd = 1'b0;
                valid  = 1'b0;
            end
        end
    endtask

    task automatic do_load(input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] t;
        byte_ev_t    ev;
        rdy_ev_t     rv;
        t         = cyc;
        req_rd    = 1'b1;
        req_wr    = 1'b0;
        req_addr  = {24'h5A3C1E, addr};
        req_wdata = 32'h0BAD_F00D;
        for (int k = 0; k < 4; k++) begin
            ev.cyc  = t + 32'(1 + k);
            ev.addr = addr + 8'(k);
            ev.data = 8'h00;
            rd_q.push_back(ev);
        end
        exp_rdata = exp;
        rv.cyc    = t + 32'd6;
        rv.rdata  = exp;
        rdy_q.push_back(rv);
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            chk("load_freeze", 32'(freeze), 32'(i <= 5));
            step();
            if (i == 0) req_addr = ~req_addr;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] t;
        byte_ev_t    ev;

        repeat (3) step();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd0);
        reset = 1'b1;
        idle(2);

        do_store(8'h10, 32'hDEADBEEF, 1'b0, -1);
        idle(1);
        do_load(8'h10, 32'hDEADBEEF);
        idle(2);

        do_store(8'hFE, 32'h01020304, 1'b0, -1);
        idle(1);
        do_load(8'hFE, 32'h01020304);
        idle(1);

        do_store(8'h40, 32'h11223344, 1'b1, -1);
        do_load(8'h40, 32'h11223344);
        idle(1);

        do_store(8'h50, 32'hCAFEF00D, 1'b0, 2);
        idle(2);
        do_load(8'h50, 32'hCAFEF00D);
        idle(1);

        do_store(8'h60, 32'h55AA6699, 1'b0, -1);
        do_load(8'h60, 32'h55AA6699);
        do_load(8'h10, 32'hDEADBEEF);
        idle(2);

        // Reset lands mid-cycle T+3, before the third byte is sampled by the RAM.
        t         = cyc;
        req_wr    = 1'b1;
        req_rd    = 1'b0;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'hA1B2C3D4;
        for (int k = 0; k < 2; k++) begin
            ev.cyc  = t + 32'(1 + k);
            ev.addr = 8'h20 + 8'(k);
            ev.data = (k == 0) ? 8'hA1 : 8'hB2;
            wr_q.push_back(ev);
        end
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("abort_mem_we", 32'(mem_we), 32'd0);
        chk("abort_mem_re", 32'(mem_re), 32'd0);
        chk("abort_freeze_req", 32'(freeze), 32'd1);
        req_wr = 1'b0;
        #1;
        chk("abort_freeze_noreq", 32'(freeze), 32'd0);
        exp_rdata = 32'h0;
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("post_rst_freeze", 32'(freeze), 32'd0);
        do_load(8'h20, 32'hA1B20000);
        idle(3);

        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("rdy_q_drained", 32'(rdy_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/byte_mem_initiator.md
Name: byte_mem_initiator

Overview:
- Requester-side counterpart to the byte-array data memory; sits between the MEM pipeline stage and a byte-wide, single-port data RAM.
- Converts one 32-bit load/store per request into four sequential byte accesses, big-endian: byte at base address = bits [31:24].
- Freezes the pipeline until the access finishes, then returns the assembled read word.

Parameters:
ADDR_W, 8, byte-address width of the RAM port (256 bytes); addresses wrap modulo 2^ADDR_W.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_rd  in  1  load request from MEM stage
req_wr  in  1  store request from MEM stage
req_addr  in  32  byte base address; only [ADDR_W-1:0] used
req_wdata  in  32  store data
freeze  out  1  stall to pipeline (combinational)
ready  out  1  one-cycle completion pulse (registered)
rdata  out  32  assembled load data (registered)
mem_addr  out  ADDR_W  RAM byte address (registered)
mem_wdata  out  8  RAM write byte (registered)
mem_we  out  1  RAM write strobe (registered)
mem_re  out  1  RAM read strobe (registered)
mem_rdata  in  8  RAM read byte, valid the cycle after mem_re

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, ready=0, rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.
- Reset mid-operation aborts immediately. Bytes already written stay in RAM; no further strobes are issued.
- req_valid = req_rd | req_wr. If both are high, the request is a store.
- freeze = req_valid & ~ready.
- States and transitions:
  - IDLE: if req_valid at edge ending cycle T, latch base=req_addr[ADDR_W-1:0], wdata=req_wdata, op. Go to WR or RD with cnt=0.
  - WR, cycles T+1..T+4: mem_we=1, mem_addr=base+k, mem_wdata=wdata byte k (k=0 → [31:24] … k=3 → [7:0]). Leave after k=3. Then DONE at T+5.
  - RD, cycles T+1..T+5:
    - Issue phase, cnt 0..3: mem_re=1, mem_addr=base+cnt.
    - Capture phase, cnt 1..4: capture mem_rdata into rdata byte cnt-1.
    - rdata changes only during an active read.
    - After cnt=4, go to DONE at T+6.
  - DONE: ready=1 for exactly this cycle; all strobes 0. Next state is IDLE.
- The next request can be accepted in the cycle after DONE at the earliest.
- Address arithmetic is ADDR_W-bit modular: base+k wraps, e.g. 0xFF+1 = 0x00.
- rdata holds its value until the next read's capture phase overwrites it; stores never modify it.
- Latched request: changes on req_* after acceptance are ignored.
- If req_valid drops mid-operation (flush), the operation still completes and ready still pulses; writes are never torn by the pipeline.
- Strobes are 0 outside WR/RD. mem_addr and mem_wdata hold their last values.

Decomposition:
- Shared package: state enum (IDLE, WR, RD, DONE), BYTES_PER_WORD=4, cnt width=3.
- No sub-module. A single FSM with a byte counter and a byte-lane mux/demux is sufficient.

Test Plan:
- Store: req_wr, addr=0x10, wdata=0xDEADBEEF at cycle T → mem_we on T+1..T+4 with (addr,data)=(10,DE),(11,AD),(12,BE),(13,EF). ready=1 at T+5 only. freeze=1 on T..T+4.
- Load: after the store, req_rd with addr=0x10 at T → mem_re on T+1..T+4 for addr 10..13. rdata=0xDEADBEEF and ready=1 at T+6.
- Wrap: store 0x01020304 at addr 0xFE → bytes 01@FE, 02@FF, 03@00, 04@01. Load from 0xFE returns 0x01020304.
- Priority and flush:
  - req_rd=req_wr=1 → write sequence only.
  - Drop req_valid at T+2 of a store → all 4 bytes still written and ready pulses at T+5.
- Reset mid-write: assert reset=0 asynchronously during T+3 of a store to 0x20 → only bytes 0x20, 0x21 written. All outputs 0 immediately; after release, state is IDLE and freeze follows req_valid.
- Back-to-back: req_wr held through ready, then switched to req_rd → second operation is accepted in the cycle after DONE, with no lost or duplicated strobes.
